// File: rtl/adder_share_sched.sv
// rtl/adder_share_sched.sv - round-robin scheduler time-sharing one external 4-bit adder
// Optional ADDSCHED_SKIP_INC_EN: skip the carry pass when the carry register is clear.
module adder_share_sched #(
    parameter int NREQ = 4,
    parameter int NIB  = 4
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    input  logic [NREQ-1:0]       iReq,
    input  logic [NREQ*4*NIB-1:0] iOpA,
    input  logic [NREQ*4*NIB-1:0] iOpB,
    output logic [NREQ-1:0]       oGnt,
    output logic [NREQ-1:0]       oDone,
    output logic [4*NIB-1:0]      oResult,
    output logic                  oCarry,
    output logic [3:0]            oAddA,
    output logic [3:0]            oAddB,
    input  logic [3:0]            iAddSum,
    input  logic                  iAddCarry
);
    localparam int W  = 4 * NIB;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, ADD, INC, DONE} stateT;

    stateT         state;
    stateT         stateNext;
    logic [PW-1:0] ptr;
    logic [PW-1:0] reqIdx;
    logic          reqFound;
    logic [W-1:0]  opA;
    logic [W-1:0]  opB;
    logic [W-1:0]  acc;
    logic [W-1:0]  accNext;
    logic [NW-1:0] nib;
    logic          lastNib;
    logic          carryReg;
    logic          c0;
    logic [3:0]    partial;
    logic [3:0]    nibA;
    logic [3:0]    nibB;

    // First requesting index after the pointer, wrapping, so the last winner ranks lowest.
    always_comb begin : arbiter
        reqFound = 1'b0;
        reqIdx   = ptr;
        for (int i = 1; i <= NREQ; i++) begin
            if (!reqFound && iReq[PW'((int'(ptr) + i) % NREQ)]) begin
                reqFound = 1'b1;
                reqIdx   = PW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    assign lastNib = (nib == NW'(NIB - 1));
    assign nibA    = 4'(opA >> {nib, 2'b00});
    assign nibB    = 4'(opB >> {nib, 2'b00});
    assign accNext = (acc & ~(W'(4'hF) << {nib, 2'b00})) | (W'(iAddSum) << {nib, 2'b00});

    always_comb begin : fsmComb
        stateNext = state;
        oAddA     = 4'h0;
        oAddB     = 4'h0;
        oDone     = '0;
        case (state)
            IDLE: begin
                if (reqFound) stateNext = ADD;
            end
            ADD: begin
                oAddA = nibA;
                oAddB = nibB;
`ifdef ADDSCHED_SKIP_INC_EN
                if (carryReg)     stateNext = INC;
                else if (lastNib) stateNext = DONE;
`else
                stateNext = INC;
`endif
            end
            INC: begin
                // Second pass folds the carry from the previous nibble into this one.
                oAddA     = partial;
                oAddB     = {3'b000, carryReg};
                stateNext = lastNib ? DONE : ADD;
            end
            DONE: begin
                oDone     = oGnt;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state <= IDLE;
        else         state <= stateNext;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ptr      <= PW'(NREQ - 1);
            oGnt     <= '0;
            opA      <= '0;
            opB      <= '0;
            acc      <= '0;
            nib      <= '0;
            carryReg <= 1'b0;
            c0       <= 1'b0;
            partial  <= 4'h0;
            oResult  <= '0;
            oCarry   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqFound) begin
                        ptr      <= reqIdx;
                        oGnt     <= NREQ'(1) << reqIdx;
                        opA      <= W'(iOpA >> (W * int'(reqIdx)));
                        opB      <= W'(iOpB >> (W * int'(reqIdx)));
                        acc      <= '0;
                        nib      <= '0;
                        carryReg <= 1'b0;
                    end
                end
                ADD: begin
`ifdef ADDSCHED_SKIP_INC_EN
                    if (!carryReg) begin
                        acc      <= accNext;
                        carryReg <= iAddCarry;
                        if (lastNib) begin
                            oResult <= accNext;
                            oCarry  <= iAddCarry;
                        end else begin
                            nib <= nib + NW'(1);
                        end
                    end else begin
                        partial <= iAddSum;
                        c0      <= iAddCarry;
                    end
`else
                    partial <= iAddSum;
                    c0      <= iAddCarry;
`endif
                end
                INC: begin
                    // c0 and the increment carry are mutually exclusive, so OR is exact.
                    acc      <= accNext;
                    carryReg <= c0 | iAddCarry;
                    if (lastNib) begin
                        oResult <= accNext;
                        oCarry  <= c0 | iAddCarry;
                    end else begin
                        nib <= nib + NW'(1);
                    end
                end
                DONE: oGnt <= '0;
                default: ;
            endcase
        end
    end
endmodule
